// File: rtl/bch_codeword_serializer.sv
// BCH(15,7) codeword serializer: captures message bits and parity and streams
// the systematic codeword out 1 bit/cycle over valid/ready.
//
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_m, i_dv           serial message bit and its valid
//   i_parity, i_done    encoder parity, sampled on the done pulse
//   o_ready             holding register empty
//   o_cw_bit/o_cw_valid serial codeword, accepted on valid & i_cw_ready
//   i_cw_ready          sink ready
//   o_sof, o_eof        first / last codeword bit qualifiers
//   o_frm_err           pulse: done with wrong message bit count
//   o_overflow          sticky: codeword dropped
//   o_chk_err           pulse: parity self-check mismatch
//
// Build option: define BCH_SELFCHECK_EN to add the parity self-check
// LFSR (g(x)=x^8+x^7+x^6+x^4+1). Without it o_chk_err is tied 0.

module bch_codeword_serializer #(
  parameter int K  = 7,
  parameter int NP = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_m,
  input  logic          i_dv,
  input  logic [NP-1:0] i_parity,
  input  logic          i_done,
  output logic          o_ready,
  output logic          o_cw_bit,
  output logic          o_cw_valid,
  input  logic          i_cw_ready,
  output logic          o_sof,
  output logic          o_eof,
  output logic          o_frm_err,
  output logic          o_overflow,
  output logic          o_chk_err
);

  localparam int N  = K + NP;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    PAR
  } state_t;

  state_t state, state_nx;

  logic [K-1:0]  msg_sr;
  logic [CW-1:0] mcnt;
  logic [N-1:0]  sh;
  logic [N-1:0]  hold;
  logic          hold_full;
  logic [IW-1:0] idx;
  logic          frm_q;
  logic          ovf_q;

  logic          word_ok;
  logic [N-1:0]  word;
  logic          accept;
  logic          last;
  logic          sh_free;

  assign word_ok = i_done && (mcnt == CW'(K));
  assign word    = {msg_sr, i_parity};
  assign accept  = o_cw_valid && i_cw_ready;
  assign last    = accept && (idx == IW'(N - 1));
  // The shifter can take a new word when idle or when its last bit
  // leaves on this edge, which gives back-to-back words without a bubble.
  assign sh_free = (state == IDLE) || last;

  // Message capture. A bit arriving with done starts the next message.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      msg_sr <= '0;
      mcnt   <= '0;
      frm_q  <= 1'b0;
    end else begin
      frm_q <= i_done && !word_ok;
      if (i_done) begin
        mcnt <= i_dv ? CW'(1) : '0;
      end else if (i_dv && (mcnt != CW'(K))) begin
        mcnt <= mcnt + CW'(1);
      end
      if (i_dv) begin
        msg_sr <= {msg_sr[K-2:0], i_m};
      end
    end
  end

  // Shifter, holding register and bit index.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      idx       <= '0;
      ovf_q     <= 1'b0;
    end else if (last && hold_full) begin
      sh  <= hold;
      idx <= '0;
      if (word_ok) begin
        hold <= word;
      end else begin
        hold_full <= 1'b0;
      end
    end else if (sh_free && word_ok) begin
      sh  <= word;
      idx <= '0;
    end else begin
      if (accept) begin
        sh  <= {sh[N-2:0], 1'b0};
        idx <= last ? '0 : idx + IW'(1);
      end
      if (word_ok) begin
        if (!hold_full) begin
          hold      <= word;
          hold_full <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // Output FSM: state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Output FSM: next state.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (word_ok) state_nx = MSG;
      end
      MSG: begin
        if (accept && (idx == IW'(K - 1))) state_nx = PAR;
      end
      PAR: begin
        if (last) begin
          state_nx = (hold_full || word_ok) ? MSG : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output FSM: outputs.
  always_comb begin
    o_cw_valid = 1'b0;
    o_cw_bit   = 1'b0;
    o_sof      = 1'b0;
    o_eof      = 1'b0;
    if (state != IDLE) begin
      o_cw_valid = 1'b1;
      o_cw_bit   = sh[N-1];
      o_sof      = (idx == IW'(0));
      o_eof      = (idx == IW'(N - 1));
    end
  end

  // Ready is forced low while reset is held.
  assign o_ready    = !hold_full && !i_rst;
  assign o_frm_err  = frm_q;
  assign o_overflow = ovf_q;

`ifdef BCH_SELFCHECK_EN
  // Low NP bits of g(x); the x^8 term is implicit in the shift-out.
  localparam logic [NP-1:0] G_LO = NP'(9'h1D1);

  logic [NP-1:0] rem;
  logic [NP-1:0] rem_step;
  logic [NP-1:0] rem_first;
  logic          fb;
  logic          chk_q;

  assign fb        = i_m ^ rem[NP-1];
  assign rem_step  = {rem[NP-2:0], 1'b0} ^ (fb ? G_LO : '0);
  assign rem_first = i_m ? G_LO : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rem   <= '0;
      chk_q <= 1'b0;
    end else begin
      chk_q <= word_ok && (rem != i_parity);
      if (i_done) begin
        rem <= i_dv ? rem_first : '0;
      end else if (i_dv) begin
        rem <= rem_step;
      end
    end
  end

  assign o_chk_err = chk_q;
`else
  assign o_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_bch_codeword_serializer.sv
// Testbench for bch_codeword_serializer: directed cases plus random
// traffic compared every cycle against a queue-based reference model.

module tb_bch_codeword_serializer;

  localparam int K  = 7;
  localparam int NP = 8;
  localparam int N  = 15;

`ifdef BCH_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_m = 1'b0;
  logic          i_dv = 1'b0;
  logic [NP-1:0] i_parity = '0;
  logic          i_done = 1'b0;
  logic          i_cw_ready = 1'b0;
  logic          o_ready;
  logic          o_cw_bit;
  logic          o_cw_valid;
  logic          o_sof;
  logic          o_eof;
  logic          o_frm_err;
  logic          o_overflow;
  logic          o_chk_err;

  int checks = 0;
  int errors = 0;

  bch_codeword_serializer #(.K(K), .NP(NP)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_m        (i_m),
    .i_dv       (i_dv),
    .i_parity   (i_parity),
    .i_done     (i_done),
    .o_ready    (o_ready),
    .o_cw_bit   (o_cw_bit),
    .o_cw_valid (o_cw_valid),
    .i_cw_ready (i_cw_ready),
    .o_sof      (o_sof),
    .o_eof      (o_eof),
    .o_frm_err  (o_frm_err),
    .o_overflow (o_overflow),
    .o_chk_err  (o_chk_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Remainder of (bits * x^8) mod 0x1D1 by plain polynomial long division.
  function automatic logic [7:0] poly_rem(input bit b[$]);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < b.size() + 8; i++) begin
      r = {r[7:0], (i < b.size()) ? b[i] : 1'b0};
      if (r[8]) r = r ^ 9'h1D1;
    end
    return r[7:0];
  endfunction

  // Reference model: bits since last done, codewords in flight (max 2),
  // position inside the head word, and the flags.
  bit           mbits[$];
  logic [N-1:0] mq[$];
  int           pos = 0;
  bit           m_ovf = 0;
  bit           m_frm = 0;
  bit           m_chk = 0;

  initial begin
    bit           acc;
    logic [K-1:0] msg;
    forever begin
      @(posedge i_clk or posedge i_rst);
      if (i_rst) begin
        mbits.delete();
        mq.delete();
        pos   = 0;
        m_ovf = 0;
        m_frm = 0;
        m_chk = 0;
      end else begin
        acc = (mq.size() > 0) && i_cw_ready;
        if (acc) begin
          if (pos == N - 1) begin
            void'(mq.pop_front());
            pos = 0;
          end else begin
            pos++;
          end
        end
        m_frm = 0;
        m_chk = 0;
        if (i_done) begin
          if (mbits.size() >= K) begin
            for (int j = 0; j < K; j++)
              msg[K-1-j] = mbits[mbits.size() - K + j];
            if (mq.size() < 2) mq.push_back({msg, i_parity});
            else m_ovf = 1;
            m_chk = SC && (poly_rem(mbits) != i_parity);
          end else begin
            m_frm = 1;
          end
          mbits.delete();
        end
        if (i_dv) mbits.push_back(i_m);
      end
    end
  end

  // Per-cycle compare and accepted-bit collector.
  bit coll[$];

  initial begin
    bit ev;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        ev = mq.size() > 0;
        chk("valid", o_cw_valid, ev);
        if (ev) chk("bit", o_cw_bit, mq[0][N-1-pos]);
        chk("sof", o_sof, ev && pos == 0);
        chk("eof", o_eof, ev && pos == N - 1);
        chk("ready", o_ready, mq.size() < 2);
        chk("frm_err", o_frm_err, m_frm);
        chk("overflow", o_overflow, m_ovf);
        chk("chk_err", o_chk_err, m_chk);
        if (o_cw_valid && i_cw_ready) coll.push_back(o_cw_bit);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic send(input logic [6:0] msg, input int n,
                      input logic [7:0] par);
    for (int i = 0; i < n; i++) begin
      i_dv = 1'b1;
      i_m  = msg[n-1-i];
      tick();
    end
    i_dv     = 1'b0;
    i_done   = 1'b1;
    i_parity = par;
    tick();
    i_done = 1'b0;
  endtask

  task automatic chk_coll(input string nm, input int nbits,
                          input logic [63:0] exp);
    logic [63:0] v;
    v = '0;
    chk({nm, "_len"}, coll.size(), nbits);
    for (int i = 0; i < coll.size() && i < 64; i++) v = {v[62:0], coll[i]};
    chk(nm, v, exp);
  endtask

  initial begin
    bit pin_bits[$];
    logic [6:0] pin_msg;
    int rdy_pct;

    // Model pin: 0101010 divides to parity 0x1A.
    pin_msg = 7'b0101010;
    for (int i = 6; i >= 0; i--) pin_bits.push_back(pin_msg[i]);
    chk("pin_poly_rem", poly_rem(pin_bits), 8'h1A);

    // Reset state.
    #1;
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_valid", o_cw_valid, 1'b0);
    tick();
    tick();
    i_rst = 1'b0;
    #1;
    chk("rel_ready", o_ready, 1'b1);
    chk("rel_ovf", o_overflow, 1'b0);
    tick();

    // 1: basic.
    i_cw_ready = 1'b1;
    coll.delete();
    send(7'b0101010, 7, 8'h1A);
    chk("t1_latency_valid", o_cw_valid, 1'b1);
    chk("t1_sof", o_sof, 1'b1);
    repeat (20) tick();
    chk_coll("t1_word", 15, 64'h2A1A);

    // 2: backpressure at idx 9.
    coll.delete();
    send(7'b0101010, 7, 8'h1A);
    repeat (9) tick();
    i_cw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_bit", o_cw_bit, 1'b0);
      chk("t2_hold_valid", o_cw_valid, 1'b1);
      if (i < 3) tick();
    end
    i_cw_ready = 1'b1;
    repeat (12) tick();
    chk_coll("t2_word", 15, 64'h2A1A);

    // 3: buffering and overflow.
    coll.delete();
    i_cw_ready = 1'b0;
    send(7'b1011001, 7, 8'hC3);
    chk("t3_ready_1", o_ready, 1'b1);
    send(7'b0010111, 7, 8'h5A);
    chk("t3_ready_2", o_ready, 1'b0);
    send(7'b1110000, 7, 8'h0F);
    chk("t3_overflow", o_overflow, 1'b1);
    i_cw_ready = 1'b1;
    repeat (30) tick();
    chk_coll("t3_two_words", 30, {34'd0, 7'b1011001, 8'hC3, 7'b0010111, 8'h5A});
    repeat (10) tick();
    chk("t3_no_third", coll.size(), 30);

    // 4: framing error then a good message.
    coll.delete();
    send(7'b0010110, 5, 8'hFF);
    chk("t4_frm_err", o_frm_err, 1'b1);
    chk("t4_no_valid", o_cw_valid, 1'b0);
    tick();
    chk("t4_frm_pulse_end", o_frm_err, 1'b0);
    send(7'b1100101, 7, 8'h55);
    repeat (20) tick();
    chk_coll("t4_word", 15, {49'd0, 7'b1100101, 8'h55});

    // 5: async reset mid-stream (idx 6 carries a 1).
    send(7'b1111111, 7, 8'hFF);
    repeat (6) tick();
    #1;
    i_rst = 1'b1;
    #1;
    chk("t5_outs_zero",
        {o_cw_valid, o_cw_bit, o_sof, o_eof, o_ready,
         o_frm_err, o_overflow, o_chk_err}, 8'h00);
    tick();
    i_rst = 1'b0;
    #1;
    chk("t5_ready", o_ready, 1'b1);
    chk("t5_valid", o_cw_valid, 1'b0);
    repeat (5) tick();
    chk("t5_still_idle", o_cw_valid, 1'b0);

    // 6: self-check.
    coll.delete();
    send(7'b0101010, 7, 8'h1B);
    chk("t6_chk_bad", o_chk_err, SC);
    repeat (20) tick();
    chk_coll("t6_word", 15, 64'h2A1B);
    send(7'b0101010, 7, 8'h1A);
    chk("t6_chk_good", o_chk_err, 1'b0);
    repeat (20) tick();

    // Random traffic.
    rdy_pct = 95;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: rdy_pct = 20;
          1: rdy_pct = 60;
          default: rdy_pct = 95;
        endcase
      end
      i_cw_ready = ($urandom_range(0, 99) < rdy_pct);
      i_dv       = ($urandom_range(0, 3) != 0);
      i_m        = 1'($urandom_range(0, 1));
      i_done     = ($urandom_range(0, 7) == 0);
      i_parity   = $urandom_range(0, 1) ? poly_rem(mbits)
                                        : 8'($urandom_range(0, 255));
      if (c == 1500) begin
        #1;
        i_rst = 1'b1;
        #1;
        chk("rnd_rst_valid", o_cw_valid, 1'b0);
        tick();
        i_rst = 1'b0;
      end else begin
        tick();
      end
    end
    i_dv       = 1'b0;
    i_done     = 1'b0;
    i_cw_ready = 1'b1;
    repeat (40) tick();
    chk("drain_idle", o_cw_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
